// File: rtl/ann_fx_pkg.sv
// Shared fixed-point definitions for the backprop gradient blocks: default Q format,
// saturation limits and the sequencing state encoding.
package ann_fx_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_FRAC_BITS  = 24;

  localparam logic [DEF_DATA_WIDTH-1:0] ONE     = 32'h0100_0000;
  localparam logic [DEF_DATA_WIDTH-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [DEF_DATA_WIDTH-1:0] SAT_MIN = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DIFF = 3'd1,
    ST_MUL1 = 3'd2,
    ST_MUL2 = 3'd3,
    ST_MUL3 = 3'd4,
    ST_DONE = 3'd5
  } state_e;

endpackage

// File: rtl/fx_mul.sv
// Combinational signed Q-format multiply: full product, floor shift by FRAC_BITS.
// DELTA_B2_1_SAT_EN selects clamping on overflow; otherwise the result wraps.
module fx_mul
  import ann_fx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAC_BITS  = DEF_FRAC_BITS
) (
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  output logic        [DATA_WIDTH-1:0] p_o
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [2*DATA_WIDTH-1:0] shifted;

  assign prod    = a_i * b_i;
  assign shifted = prod >>> FRAC_BITS;

`ifdef DELTA_B2_1_SAT_EN
  localparam logic [DATA_WIDTH-1:0] MAX_V = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MIN_V = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Fits only if every bit above the kept sign bit replicates it.
  logic fits;
  assign fits = (shifted[2*DATA_WIDTH-1:DATA_WIDTH-1] == '0) ||
                (shifted[2*DATA_WIDTH-1:DATA_WIDTH-1] == '1);
  assign p_o  = fits ? shifted[DATA_WIDTH-1:0]
                     : (shifted[2*DATA_WIDTH-1] ? MIN_V : MAX_V);
`else
  logic unused_hi;
  assign unused_hi = ^shifted[2*DATA_WIDTH-1:DATA_WIDTH];
  assign p_o       = shifted[DATA_WIDTH-1:0];
`endif

endmodule

// File: rtl/delta_b2_1.sv
// Output-layer bias gradient db2_1 = eta*(t-a2)*a2*(1-a2) on one shared multiplier.
// DELTA_B2_1_SAT_EN enables saturating arithmetic; default build wraps.
//
// state | meaning
// IDLE  | waiting for start; captures a2/t/eta on accept
// DIFF  | e = t - a2, m = ONE - a2
// MUL1  | p = e * a2
// MUL2  | p = p * m
// MUL3  | db2_1 = p * eta
// DONE  | select_update strobe, back to IDLE
module delta_b2_1
  import ann_fx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAC_BITS  = DEF_FRAC_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a2,
  input  logic [DATA_WIDTH-1:0] t,
  input  logic [DATA_WIDTH-1:0] eta,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] db2_1,
  output logic                  select_update
);

  localparam logic [DATA_WIDTH-1:0] ONE_W = DATA_WIDTH'(1) << FRAC_BITS;
`ifdef DELTA_B2_1_SAT_EN
  localparam logic [DATA_WIDTH-1:0] MAX_V = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MIN_V = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif

  state_e state_q, state_d;
  logic [DATA_WIDTH-1:0] a2_q, t_q, eta_q, e_q, m_q, p_q, db_q;
  logic [DATA_WIDTH-1:0] mul_a, mul_b, mul_p;
  logic                  sel_q;

  function automatic logic [DATA_WIDTH-1:0] sub_ovf(input logic [DATA_WIDTH-1:0] x,
                                                    input logic [DATA_WIDTH-1:0] y);
`ifdef DELTA_B2_1_SAT_EN
    logic [DATA_WIDTH:0] d;
    d = {x[DATA_WIDTH-1], x} - {y[DATA_WIDTH-1], y};
    if (d[DATA_WIDTH] != d[DATA_WIDTH-1]) return d[DATA_WIDTH] ? MIN_V : MAX_V;
    return d[DATA_WIDTH-1:0];
`else
    return x - y;
`endif
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    mul_a   = p_q;
    mul_b   = m_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_DIFF;
      ST_DIFF: state_d = ST_MUL1;
      ST_MUL1: begin
        state_d = ST_MUL2;
        mul_a   = e_q;
        mul_b   = a2_q;
      end
      ST_MUL2: state_d = ST_MUL3;
      ST_MUL3: begin
        state_d = ST_DONE;
        mul_b   = eta_q;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  fx_mul #(.DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS)) u_mul (
    .a_i(mul_a),
    .b_i(mul_b),
    .p_o(mul_p)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a2_q  <= '0;
      t_q   <= '0;
      eta_q <= '0;
      e_q   <= '0;
      m_q   <= '0;
      p_q   <= '0;
      db_q  <= '0;
      sel_q <= 1'b0;
    end else begin
      // Strobe is registered so it lines up exactly with the DONE cycle.
      sel_q <= (state_q == ST_MUL3);
      case (state_q)
        ST_IDLE: if (start) begin
          a2_q  <= a2;
          t_q   <= t;
          eta_q <= eta;
        end
        ST_DIFF: begin
          e_q <= sub_ovf(t_q, a2_q);
          m_q <= sub_ovf(ONE_W, a2_q);
        end
        ST_MUL1, ST_MUL2: p_q  <= mul_p;
        ST_MUL3:          db_q <= mul_p;
        default: ;
      endcase
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign db2_1         = db_q;
  assign select_update = sel_q;

endmodule

// File: tb/tb_delta_b2_1.sv
// Directed and randomized checks of delta_b2_1 against an arithmetic reference model.
module tb_delta_b2_1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a2 = '0, t = '0, eta = '0;
  logic        busy;
  logic [31:0] db2_1;
  logic        select_update;

  delta_b2_1 dut (
    .clk(clk), .reset(reset), .start(start), .a2(a2), .t(t), .eta(eta),
    .busy(busy), .db2_1(db2_1), .select_update(select_update)
  );

  always #5 clk = ~clk;

  int checks = 0, passed = 0, fails = 0, strobes = 0;
  logic [31:0] last_db = '0;

  always @(negedge clk) if (select_update) strobes++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input logic [31:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint fit(input longint v);
`ifdef DELTA_B2_1_SAT_EN
    if (v > 64'sd2147483647)  return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
`else
    logic [31:0] lo;
    lo = v[31:0];
    return sx(lo);
`endif
  endfunction

  // Real-valued product scaled by 2^24, rounded toward minus infinity.
  function automatic longint qmul(input longint x, input longint y);
    longint pr, q;
    pr = x * y;
    q  = pr / 64'sd16777216;
    if (pr < 0 && (pr % 64'sd16777216) != 0) q = q - 1;
    return fit(q);
  endfunction

  function automatic logic [31:0] model(input logic [31:0] tv, input logic [31:0] av,
                                        input logic [31:0] ev);
    longint e, m, p;
    logic [63:0] r;
    e = fit(sx(tv) - sx(av));
    m = fit(64'sd16777216 - sx(av));
    p = qmul(e, sx(av));
    p = qmul(p, m);
    r = qmul(p, sx(ev));
    return r[31:0];
  endfunction

  function automatic logic [31:0] rand_q();
    if ($urandom_range(0, 1) == 1) return $urandom();
    return 32'($urandom_range(0, 32'h0400_0000)) - 32'h0200_0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_calc(input string tag, input logic [31:0] tv, input logic [31:0] av,
                          input logic [31:0] ev);
    logic [31:0] exp;
    int s0;
    exp = model(tv, av, ev);
    s0  = strobes;
    start = 1'b1; t = tv; a2 = av; eta = ev;
    tick();
    start = 1'b0;
    check({tag, "_busy_e0"}, 32'(busy), 32'd1);
    t = $urandom(); a2 = $urandom(); eta = $urandom();
    repeat (3) tick();
    check({tag, "_hold_e3"}, db2_1, last_db);
    check({tag, "_sel_e3"}, 32'(select_update), 32'd0);
    tick();
    check({tag, "_db_e4"}, db2_1, exp);
    check({tag, "_sel_e4"}, 32'(select_update), 32'd1);
    tick();
    check({tag, "_sel_e5"}, 32'(select_update), 32'd0);
    check({tag, "_busy_e5"}, 32'(busy), 32'd0);
    check({tag, "_strobes"}, 32'(strobes - s0), 32'd1);
    last_db = exp;
  endtask

  initial begin
    logic [31:0] ea, eb;
    int s0;

    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_db", db2_1, 32'd0);
    check("rst_sel", 32'(select_update), 32'd0);
    reset = 1'b1;
    tick();

    run_calc("basic", 32'h0100_0000, 32'h0080_0000, 32'h0080_0000);
    check("basic_const", last_db, 32'h0010_0000);
    run_calc("neg", 32'h0000_0000, 32'h0080_0000, 32'h0080_0000);
    check("neg_const", last_db, 32'hFFF0_0000);

    // Reset while in MUL2.
    s0 = strobes;
    start = 1'b1; t = 32'h0100_0000; a2 = 32'h0080_0000; eta = 32'h0080_0000;
    tick();
    start = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_db", db2_1, 32'd0);
    check("midrst_sel", 32'(select_update), 32'd0);
    #2 reset = 1'b1;
    last_db = '0;
    repeat (10) tick();
    check("midrst_nostrobe", 32'(strobes - s0), 32'd0);
    check("midrst_idle", 32'(busy), 32'd0);

    // Start pulsed while busy is ignored.
    s0 = strobes;
    start = 1'b1; t = 32'h0100_0000; a2 = 32'h0080_0000; eta = 32'h0080_0000;
    tick();
    start = 1'b0;
    repeat (2) tick();
    start = 1'b1; t = 32'h0000_0000; a2 = 32'h0030_0000; eta = 32'h0100_0000;
    tick();
    start = 1'b0;
    tick();
    check("ign_db", db2_1, 32'h0010_0000);
    check("ign_sel", 32'(select_update), 32'd1);
    repeat (5) tick();
    check("ign_strobes", 32'(strobes - s0), 32'd1);
    check("ign_idle", 32'(busy), 32'd0);
    last_db = 32'h0010_0000;

    run_calc("sat", 32'h4000_0000, 32'hF000_0000, 32'h0100_0000);
`ifdef DELTA_B2_1_SAT_EN
    check("sat_const", db2_1, 32'h8000_0000);
`else
    check("wrap_const", db2_1, 32'h0000_0000);
`endif

    for (int i = 0; i < 12; i++) run_calc("rnd", rand_q(), rand_q(), rand_q());

    // Back-to-back with start held high.
    s0 = strobes;
    ea = model(32'h0100_0000, 32'h0040_0000, 32'h0100_0000);
    eb = model(32'h0000_0000, 32'h00C0_0000, 32'h0200_0000);
    start = 1'b1; t = 32'h0100_0000; a2 = 32'h0040_0000; eta = 32'h0100_0000;
    tick();
    t = 32'h0000_0000; a2 = 32'h00C0_0000; eta = 32'h0200_0000;
    repeat (4) tick();
    check("b2b_sel_e4", 32'(select_update), 32'd1);
    check("b2b_db_e4", db2_1, ea);
    tick();
    check("b2b_idle_e5", 32'(busy), 32'd0);
    tick();
    start = 1'b0;
    check("b2b_busy_e6", 32'(busy), 32'd1);
    repeat (3) tick();
    check("b2b_hold_e9", db2_1, ea);
    check("b2b_sel_e9", 32'(select_update), 32'd0);
    tick();
    check("b2b_sel_e10", 32'(select_update), 32'd1);
    check("b2b_db_e10", db2_1, eb);
    repeat (2) tick();
    check("b2b_strobes", 32'(strobes - s0), 32'd2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
